// File: rtl/inv2_iter_hs.sv
// Iterative 2x2 fixed-point matrix inverse with valid/ready handshakes.
// det -> restoring 1/det divider -> adjugate scaling on one shared multiplier.
module inv2_iter_hs #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  input  logic signed [N-1:0] c,
  input  logic signed [N-1:0] d,
  input  logic                sym,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] IA,
  output logic signed [N-1:0] IB,
  output logic signed [N-1:0] IC,
  output logic signed [N-1:0] ID,
  output logic                singular,
  output logic                sat
);

  localparam int ITER = 3*FRAC + 1;
  localparam int DW   = 2*N + 1;
  localparam int RW   = ITER + 1;
  localparam int PW   = N + 1 + RW;
  localparam int CW   = $clog2(ITER);

  localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (N-1)) - 64'sd1);
  localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

  typedef enum logic [2:0] {IDLE, DET, DIV, SCALE, OUT} state_t;

  state_t                state;
  logic signed [N-1:0]   a_q, b_q, c_q, d_q;
  logic                  sym_q;
  logic                  det_neg;
  logic        [DW-1:0]  divisor;
  logic        [DW-1:0]  rem;
  logic        [ITER-1:0] quo;
  logic        [CW-1:0]  bit_cnt;
  logic signed [RW-1:0]  r_q;
  logic        [1:0]     slot;
  logic signed [N-1:0]   ia_q, ib_q, ic_q;
  logic                  sat_acc;

  // Determinant at full precision (2*FRAC fractional bits)
  logic signed [DW-1:0] a_x, b_x, c_x, d_x, det_full;
  logic        [DW-1:0] det_abs;

  assign a_x      = $signed({{(DW-N){a_q[N-1]}}, a_q});
  assign b_x      = $signed({{(DW-N){b_q[N-1]}}, b_q});
  assign c_x      = $signed({{(DW-N){c_q[N-1]}}, c_q});
  assign d_x      = $signed({{(DW-N){d_q[N-1]}}, d_q});
  assign det_full = (a_x * d_x) - (b_x * c_x);
  assign det_abs  = det_full[DW-1] ? $unsigned(-det_full) : $unsigned(det_full);

  // One restoring step; the dividend 2^(3*FRAC) contributes only its top bit
  logic          dvd_bit;
  logic [DW:0]   rem_sh;
  logic          ge;
  logic [DW-1:0] rem_nx;
  logic [ITER-1:0] quo_nx;

  always_comb begin
    dvd_bit = (bit_cnt == CW'(ITER-1));
    rem_sh  = {rem, dvd_bit};
    ge      = (rem_sh >= {1'b0, divisor});
    rem_nx  = ge ? DW'(rem_sh - {1'b0, divisor}) : rem_sh[DW-1:0];
    quo_nx  = quo;
    quo_nx[bit_cnt] = ge;
  end

  // Shared multiplier; negation is done at N+1 bits so -(-2^(N-1)) does not wrap
  logic signed [N:0]    op;
  logic signed [PW-1:0] op_x, r_x, prod, shifted;
  logic signed [N-1:0]  res;
  logic                 clamp;

  always_comb begin
    case (slot)
      2'd0:    op = $signed({d_q[N-1], d_q});
      2'd1:    op = -$signed({b_q[N-1], b_q});
      2'd2:    op = -$signed({c_q[N-1], c_q});
      default: op = $signed({a_q[N-1], a_q});
    endcase
    op_x    = $signed({{(PW-N-1){op[N]}}, op});
    r_x     = $signed({{(PW-RW){r_q[RW-1]}}, r_q});
    prod    = op_x * r_x;
    shifted = prod >>> FRAC;
    clamp   = 1'b0;
    res     = shifted[N-1:0];
    if (shifted > MAXV) begin
      clamp = 1'b1;
      res   = MAXV[N-1:0];
    end else if (shifted < MINV) begin
      clamp = 1'b1;
      res   = MINV[N-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      IA        <= '0;
      IB        <= '0;
      IC        <= '0;
      ID        <= '0;
      singular  <= 1'b0;
      sat       <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      sym_q     <= 1'b0;
      det_neg   <= 1'b0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      bit_cnt   <= '0;
      r_q       <= '0;
      slot      <= '0;
      ia_q      <= '0;
      ib_q      <= '0;
      ic_q      <= '0;
      sat_acc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            c_q      <= sym ? b : c;
            d_q      <= d;
            sym_q    <= sym;
            in_ready <= 1'b0;
            state    <= DET;
          end
        end
        DET: begin
          if (det_full == '0) begin
            singular  <= 1'b1;
            sat       <= 1'b0;
            IA        <= '0;
            IB        <= '0;
            IC        <= '0;
            ID        <= '0;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            divisor <= det_abs;
            det_neg <= det_full[DW-1];
            rem     <= '0;
            quo     <= '0;
            bit_cnt <= CW'(ITER-1);
            state   <= DIV;
          end
        end
        DIV: begin
          rem     <= rem_nx;
          quo     <= quo_nx;
          bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == '0) begin
            r_q     <= det_neg ? -$signed({1'b0, quo_nx}) : $signed({1'b0, quo_nx});
            slot    <= 2'd0;
            sat_acc <= 1'b0;
            state   <= SCALE;
          end
        end
        SCALE: begin
          sat_acc <= sat_acc | clamp;
          case (slot)
            2'd0: begin
              ia_q <= res;
              slot <= 2'd1;
            end
            2'd1: begin
              ib_q <= res;
              slot <= sym_q ? 2'd3 : 2'd2;
            end
            2'd2: begin
              ic_q <= res;
              slot <= 2'd3;
            end
            default: begin
              // All four elements are published together on the last product
              IA        <= ia_q;
              IB        <= ib_q;
              IC        <= sym_q ? ib_q : ic_q;
              ID        <= res;
              singular  <= 1'b0;
              sat       <= sat_acc | clamp;
              out_valid <= 1'b1;
              state     <= OUT;
            end
          endcase
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inv2_iter_hs.sv
// Directed self-checking bench for inv2_iter_hs (N=20, FRAC=10, S=1024).
module tb_inv2_iter_hs;

  localparam int N = 20;
  localparam int S = 1024;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid, in_ready, sym, out_valid, out_ready;
  logic signed [N-1:0] a, b, c, d;
  logic signed [N-1:0] ia, ib, ic, id;
  logic                singular, sat;

  int tests_run = 0;
  int tests_failed = 0;

  inv2_iter_hs #(.N(N), .FRAC(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .sym(sym),
    .out_valid(out_valid), .out_ready(out_ready),
    .IA(ia), .IB(ib), .IC(ic), .ID(id),
    .singular(singular), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one operand set, returns right after the accept edge
  task automatic applyStimulus(input int va, input int vb, input int vc, input int vd, input logic vs);
    a = N'(va); b = N'(vb); c = N'(vc); d = N'(vd); sym = vs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = N'(12345); b = N'(-777); c = N'(31); d = N'(-9);
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runCase(input string name, input int va, input int vb, input int vc, input int vd,
                         input logic vs, input int e_ia, input int e_ib, input int e_ic, input int e_id,
                         input int e_sing, input int e_sat, input int e_lat);
    int lat;
    applyStimulus(va, vb, vc, vd, vs);
    checkOutput({name, " in_ready busy"}, in_ready, 0);
    waitValid(lat);
    checkOutput({name, " latency"}, lat, e_lat);
    checkOutput({name, " IA"}, ia, e_ia);
    checkOutput({name, " IB"}, ib, e_ib);
    checkOutput({name, " IC"}, ic, e_ic);
    checkOutput({name, " ID"}, id, e_id);
    checkOutput({name, " singular"}, singular, e_sing);
    checkOutput({name, " sat"}, sat, e_sat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, " out_valid drop"}, out_valid, 0);
    checkOutput({name, " in_ready back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sym = 1'b0;
    a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset out_valid", out_valid, 0);
    checkOutput("reset IA", ia, 0);
    checkOutput("reset ID", id, 0);
    checkOutput("reset singular", singular, 0);
    checkOutput("reset sat", sat, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // det = 8, r = 128
    runCase("diag", 2*S, 0, 0, 4*S, 1'b0, 512, 0, 0, 256, 0, 0, 36);
    // det = -2, r = -512
    runCase("general", S, 2*S, 3*S, 4*S, 1'b0, -2048, 1024, 1536, -512, 0, 0, 36);
    // det = 3, r = floor(2^30/3145728) = 341; -1024*341 >>> 10 = -341 exactly
    runCase("sym", 2*S, S, 9*S, 2*S, 1'b1, 682, -341, -341, 682, 0, 0, 35);
    runCase("singular", S, S, S, S, 1'b0, 0, 0, 0, 0, 1, 0, 1);
    // det = 2^-20, r = 2^30, products 2^20 clamp
    runCase("clamp", 1, 0, 0, 1, 1'b0, 524287, 0, 0, 524287, 0, 1, 36);
    // -b for b = -2^19 must not wrap: det = 1 (units of 2^-20), IB would be +2^29 -> clamp high
    runCase("negmin", 1, -524288, 0, 1, 1'b0, 524287, 524287, 0, 524287, 0, 1, 36);

    // Back-pressure: result held, busy input ignored
    applyStimulus(2*S, 0, 0, 4*S, 1'b0);
    waitValid(lat);
    checkOutput("hold latency", lat, 36);
    for (int i = 0; i < 5; i++) begin
      a = N'(S); b = N'(S); c = N'(S); d = N'(S);
      in_valid = 1'b1;
      @(posedge clk); #1;
      checkOutput("hold out_valid", out_valid, 1);
      checkOutput("hold in_ready", in_ready, 0);
      checkOutput("hold IA", ia, 512);
      checkOutput("hold ID", id, 256);
      checkOutput("hold singular", singular, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("hold out_valid drop", out_valid, 0);
    checkOutput("hold in_ready back", in_ready, 1);
    checkOutput("idle keeps IA", ia, 512);
    @(posedge clk); #1;
    checkOutput("ignored input no start", in_ready, 1);

    // Abort mid-division
    applyStimulus(S, 2*S, 3*S, 4*S, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort out_valid", out_valid, 0);
    checkOutput("abort in_ready", in_ready, 1);
    checkOutput("abort IA", ia, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    runCase("after abort", 2*S, 0, 0, 4*S, 1'b0, 512, 0, 0, 256, 0, 0, 36);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
